// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and bit-timing helper for the UART.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   typedef state_t tx_state_t;
   typedef state_t rx_state_t;
   function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronises rx, rejects start glitches, samples mid-bit and
// reports a word only after a valid stop bit has fully elapsed.
module uart_rx import uart_pkg::*; #(
   parameter int CLKS = 5208,
   parameter int DATA_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid
);
   localparam int CW = $clog2(2 * CLKS);
   localparam int BW = $clog2(DATA_BITS + 1);
   rx_state_t state;
   logic s1, s2, err;
   logic [CW-1:0] cnt;
   logic [BW-1:0] idx;
   logic [DATA_BITS-1:0] sh;
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         err <= 1'b0;
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         data <= '0;
         valid <= 1'b0;
      end else begin
         s1 <= rx;
         s2 <= s1;
         valid <= 1'b0;
         cnt <= cnt + CW'(1);
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!s2) state <= START;
            end
            START: if (cnt == CW'((CLKS - 1) / 2)) begin
               cnt <= '0;
               idx <= '0;
               state <= s2 ? IDLE : DATA;
            end
            DATA: if (cnt == CW'(CLKS - 1)) begin
               cnt <= '0;
               sh <= {s2, sh[DATA_BITS-1:1]};
               idx <= idx + BW'(1);
               if (idx == BW'(DATA_BITS - 1)) state <= STOP;
            end
            // A low stop bit is a framing error: hold until the line idles again.
            STOP: if (err) begin
               cnt <= '0;
               if (s2) begin
                  err <= 1'b0;
                  state <= IDLE;
               end
            end else if (cnt == CW'(CLKS - 1) && !s2) begin
               err <= 1'b1;
            end else if (cnt == CW'(CLKS - 1 + CLKS / 2)) begin
               data <= sh;
               valid <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one word per frame as start bit, LSB-first data, stop bit.
module uart_tx import uart_pkg::*; #(
   parameter int CLKS = 5208,
   parameter int DATA_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 send,
   output logic                 busy,
   output logic                 tx
);
   localparam int CW = $clog2(CLKS + 1);
   localparam int BW = $clog2(DATA_BITS + 1);
   tx_state_t state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] idx;
   logic [DATA_BITS-1:0] sh;
   logic bit_end;
   assign bit_end = cnt == CW'(CLKS - 1);
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         busy <= 1'b0;
         tx <= 1'b1;
      end else begin
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
         case (state)
            IDLE: if (send) begin
               sh <= data;
               tx <= 1'b0;
               busy <= 1'b1;
               state <= START;
            end
            START: if (bit_end) begin
               tx <= sh[0];
               sh <= sh >> 1;
               idx <= '0;
               state <= DATA;
            end
            DATA: if (bit_end) begin
               if (idx == BW'(DATA_BITS - 1)) begin
                  tx <= 1'b1;
                  state <= STOP;
               end else begin
                  tx <= sh[0];
                  sh <= sh >> 1;
                  idx <= idx + BW'(1);
               end
            end
            STOP: if (bit_end) begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/uart.sv
// uart: full-duplex 8N1-style UART top level, wiring only.
module uart import uart_pkg::*; #(
   parameter int BAUD_RATE = 9600,
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int DATA_BITS = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_send,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx,
   output logic                 tx
);
   localparam int CLKS = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   uart_tx #(.CLKS(CLKS), .DATA_BITS(DATA_BITS)) tx_inst (
      .clock(clock), .reset(reset), .data(tx_data), .send(tx_send), .busy(tx_busy), .tx(tx)
   );
   uart_rx #(.CLKS(CLKS), .DATA_BITS(DATA_BITS)) rx_inst (
      .clock(clock), .reset(reset), .rx(rx), .data(rx_data), .valid(rx_valid)
   );
endmodule

// File: tb/tb_uart.sv
// tb_uart: randomized loopback and direct-drive bench with a scoreboard of
// expected received words and expected transmitted frames.
module tb_uart;
   localparam int BAUD = 100_000;
   localparam int FREQ = 6_400_000;
   localparam int C = FREQ / BAUD;
   logic clock = 1'b0, reset = 1'b1, tx_send = 1'b0, rx_drv = 1'b1, loop = 1'b1;
   logic tx_busy, rx_valid, tx, rx;
   logic [7:0] tx_data = '0, rx_data, last_good = '0;
   logic [7:0] sb[$], txq[$];
   int checks = 0, fails = 0, rst_cnt = 0;
   assign rx = loop ? tx : rx_drv;
   always #5 clock = ~clock;
   uart #(.BAUD_RATE(BAUD), .CLOCK_FREQ(FREQ), .DATA_BITS(8)) dut (
      .clock(clock), .reset(reset), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx(rx), .tx(tx)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // receive-side scoreboard
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clock);
         if (rx_valid) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL rx_unexpected: got word %0h, expected none at %0t", rx_data, $time);
            end else begin
               e = sb.pop_front();
               chk("rx_data", rx_data, e);
               last_good = e;
            end
         end
      end
   end
   // transmit-side frame checker: mid-bit samples, busy length, idle level
   initial begin
      logic [9:0] fr;
      int n, rc;
      bit abort;
      forever begin
         do @(negedge clock); while (!(tx_busy && !reset));
         rc = rst_cnt;
         if (txq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL tx_unexpected: got a frame, expected none at %0t", $time);
            fr = '1;
         end else fr = {1'b1, txq.pop_front(), 1'b0};
         n = 0;
         abort = 0;
         while (tx_busy && !abort) begin
            if (n % C == C / 2 && n / C < 10) chk("tx_bit", tx, fr[n/C]);
            @(negedge clock);
            n++;
            if (rst_cnt != rc) abort = 1;
         end
         if (!abort) begin
            chk("busy_len", n, 10 * C);
            chk("tx_idle", tx, 1);
         end
      end
   end
   task automatic wait_idle();
      int n = 0;
      while (tx_busy && n < 20 * C) begin
         @(negedge clock);
         n++;
      end
      chk("idle_timeout", tx_busy, 0);
   endtask
   task automatic send(input logic [7:0] d);
      wait_idle();
      tx_data = d;
      tx_send = 1'b1;
      sb.push_back(d);
      txq.push_back(d);
      @(negedge clock);
      tx_send = 1'b0;
      tx_data = 8'($urandom);
      chk("busy_rise", tx_busy, 1);
   endtask
   task automatic junk_send();
      repeat ($urandom_range(10, 8 * C)) @(negedge clock);
      if (tx_busy) begin
         tx_data = 8'($urandom);
         tx_send = 1'b1;
         @(negedge clock);
         tx_send = 1'b0;
      end
   endtask
   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || tx_busy) && n < 30 * C) begin
         @(negedge clock);
         n++;
      end
      repeat (8) @(negedge clock);
      chk("drain", sb.size(), 0);
   endtask
   task automatic drive_frame(input logic [7:0] d, input logic stop);
      rx_drv = 1'b0;
      repeat (C) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (C) @(negedge clock);
      end
      rx_drv = stop;
      repeat (C) @(negedge clock);
      rx_drv = 1'b1;
      repeat (2 * C) @(negedge clock);
   endtask
   initial begin
      logic [7:0] d;
      repeat (20) @(negedge clock);
      chk("reset_tx", tx, 1);
      chk("reset_busy", tx_busy, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_valid", rx_valid, 0);
      reset = 1'b0;
      send(8'h55);
      drain();
      foreach (sb[i]) d = sb[i];
      send(8'h00);
      send(8'hFF);
      send(8'hA5);
      send(8'h01);
      drain();
      send(8'h96);
      repeat (3 * C) @(negedge clock);
      tx_data = 8'h3C;
      tx_send = 1'b1;
      @(negedge clock);
      tx_send = 1'b0;
      drain();
      loop = 1'b0;
      repeat (4) @(negedge clock);
      rx_drv = 1'b0;
      repeat (C / 4) @(negedge clock);
      rx_drv = 1'b1;
      repeat (2 * C) @(negedge clock);
      chk("glitch_hold", rx_data, last_good);
      drive_frame(8'($urandom), 1'b0);
      chk("frame_err_hold", rx_data, last_good);
      d = 8'($urandom);
      sb.push_back(d);
      drive_frame(d, 1'b1);
      drain();
      loop = 1'b1;
      repeat (4) @(negedge clock);
      send(8'h81);
      repeat (4 * C) @(negedge clock);
      reset = 1'b1;
      rst_cnt++;
      sb.delete();
      txq.delete();
      last_good = '0;
      @(negedge clock);
      chk("midreset_tx", tx, 1);
      chk("midreset_busy", tx_busy, 0);
      chk("midreset_rx_valid", rx_valid, 0);
      reset = 1'b0;
      send(8'h81);
      drain();
      for (int i = 0; i < 12; i++) begin
         send(8'($urandom));
         if ($urandom_range(0, 2) == 0) junk_send();
         repeat ($urandom_range(0, C)) @(negedge clock);
      end
      drain();
      chk("txq_empty", txq.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
   initial begin
      #(80_000 * 10);
      fails++;
      $display("FAIL watchdog: run exceeded time limit");
      $display("%0d/%0d checks passed", checks - fails, checks);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart.md
Name: uart

Overview:
- Full-duplex 8N1-style UART: a transmitter serialises a parallel word onto `tx`, and a receiver deserialises `rx` into a parallel word.
- Fixed baud rate derived from the system clock by an integer divide; no FIFOs and no parity.
- Sits between a host-side byte interface and the board serial pins.
- Benches exercise it in external loopback (`rx` tied to `tx`).

Parameters:
- BAUD_RATE, 9600, serial bit rate in bits/s.
- CLOCK_FREQ, 50_000_000, clock frequency in Hz.
- DATA_BITS, 8, data bits per frame.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  word to transmit; sampled when tx_send is accepted.
- tx_send  input  1  request to transmit; accepted only when idle.
- tx_busy  output  1  high while a frame is being transmitted.
- rx_data  output  DATA_BITS  last correctly received word.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx  input  1  serial input; asynchronous, idle high.
- tx  output  1  serial output; registered, idle high.

Behaviour:
- Bit timing:
  - CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer-truncated (5208 at defaults).
  - Every transmitted bit lasts exactly CLKS_PER_BIT cycles.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Reset values:
  - tx=1, tx_busy=0, rx_data=0, rx_valid=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset mid-frame aborts immediately; tx returns high on the next edge.
- TX FSM states IDLE, START, DATA, STOP:
  - IDLE: tx=1, tx_busy=0. When tx_send=1 at an edge, latch tx_data into a shift register and go to START. tx=0 and tx_busy=1 appear after that same edge.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive the shift register LSB for CLKS_PER_BIT cycles per bit. After DATA_BITS bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with tx_busy=0.
  - tx_busy is high for exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - tx_send while busy is ignored (not queued).
  - tx_data changes after acceptance do not affect the frame.
  - tx_send held high across the return to IDLE starts a new frame on the first IDLE edge.
- RX input sync: rx passes through a 2-flop synchronizer before any use.
- RX FSM states IDLE, START, DATA, STOP:
  - IDLE: wait for synchronized rx=0, then go to START with the counter cleared.
  - START: at (CLKS_PER_BIT-1)/2 cycles, resample. If still 0, go to DATA. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) into a shift register, LSB first. After DATA_BITS samples, go to STOP.
  - STOP: sample at mid-bit.
    - If 1: wait a further CLKS_PER_BIT/2 cycles (end of stop bit). Then load rx_data, pulse rx_valid for exactly one cycle, and go to IDLE.
    - If 0 (framing error): rx_data is unchanged, no rx_valid; wait for rx=1, then go to IDLE.
  - rx_valid therefore fires a few cycles after the far-end stop bit ends. In loopback this is strictly after tx_busy falls; at defaults it is at most 5 cycles later.
  - rx_data holds its value until the next good frame.
- TX and RX are independent and may run simultaneously.
- State registers use enumerated types so state names are visible in simulation.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - typedef enum rx_state_t {IDLE, START, DATA, STOP};
  - a function computing CLKS_PER_BIT.
- Top-level uart instantiates sub-module uart_tx as tx_inst and sub-module uart_rx as rx_inst. Each exposes an internal register named state for hierarchical debug.
- Top level is wiring only.

Test Plan:
- Loopback, reset 200 ns, then send 0x55:
  - tx_busy rises one cycle after acceptance and lasts 10*5208 cycles.
  - rx_valid pulses once after tx_busy falls, with rx_data=0x55.
- Back-to-back 0x00, 0xFF, 0xA5, 0x01 → each received in order with matching rx_data; tx idles high between frames.
- tx_send=1 for one cycle mid-frame with tx_data=0x3C → ignored; the current frame is unchanged and only one rx_valid occurs.
- Receiver driven separately:
  - A low glitch of 1000 cycles on rx → no rx_valid.
  - A frame with stop bit 0 → no rx_valid, rx_data retains its previous value.
- Assert reset for one cycle midway through the DATA state of 0x81 → next cycle tx=1, tx_busy=0, rx_valid=0; a subsequent send of 0x81 is received correctly.
